// File: rtl/vec_exec_pipe.sv
//==============================================================================
// Module   : vec_exec_pipe
// Brief    : Parametrised LANES x EW vector ALU with valid/ready pipeline,
//            flush, scalar broadcast, optional signed saturation and zero mask.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vec_exec_pipe #(
    parameter int LANES  = 8,
    parameter int EW     = 32,
    parameter int STAGES = 2,
    parameter int SAT    = 0,
    parameter int TAGW   = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*EW-1:0]   srca,
    input  logic [LANES*EW-1:0]   srcb,
    input  logic [EW-1:0]         scalarb,
    input  logic                  scalar,
    input  logic [2:0]            alucontrol,
    input  logic [TAGW-1:0]       tag_in,
    input  logic                  wen_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*EW-1:0]   result,
    output logic [LANES-1:0]      zmask,
    output logic [TAGW-1:0]       tag_out,
    output logic                  wen_out
);

    localparam int c_VW = LANES * EW;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SLT = 3'b101;
    localparam logic [2:0] c_OP_MIN = 3'b110;
    localparam logic [2:0] c_OP_MAX = 3'b111;

    localparam logic [EW-1:0] c_SMAX = {1'b0, {(EW-1){1'b1}}};
    localparam logic [EW-1:0] c_SMIN = {1'b1, {(EW-1){1'b0}}};

    logic [c_VW-1:0]  w_laneRes;
    logic [LANES-1:0] w_laneZero;

    //--------------------------------------------------------------------------
    // Per-lane datapath
    //--------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [EW-1:0] w_a;
            logic [EW-1:0] w_b;
            logic [EW-1:0] w_sum;
            logic [EW-1:0] w_diff;
            logic [EW-1:0] w_clamp;
            logic [EW-1:0] w_res;
            logic          w_addOvf;
            logic          w_subOvf;
            logic          w_lt;

            assign w_a    = srca[i*EW +: EW];
            assign w_b    = scalar ? scalarb : srcb[i*EW +: EW];
            assign w_sum  = w_a + w_b;
            assign w_diff = w_a - w_b;

            // Signed overflow always saturates toward the sign of operand a.
            assign w_addOvf = (w_a[EW-1] == w_b[EW-1]) && (w_sum[EW-1]  != w_a[EW-1]);
            assign w_subOvf = (w_a[EW-1] != w_b[EW-1]) && (w_diff[EW-1] != w_a[EW-1]);
            assign w_clamp  = w_a[EW-1] ? c_SMIN : c_SMAX;
            assign w_lt     = $signed(w_a) < $signed(w_b);

            always_comb begin
                w_res = w_sum;
                case (alucontrol)
                    c_OP_ADD: w_res = ((SAT != 0) && w_addOvf) ? w_clamp : w_sum;
                    c_OP_SUB: w_res = ((SAT != 0) && w_subOvf) ? w_clamp : w_diff;
                    c_OP_AND: w_res = w_a & w_b;
                    c_OP_OR:  w_res = w_a | w_b;
                    c_OP_XOR: w_res = w_a ^ w_b;
                    c_OP_SLT: w_res = {{(EW-1){1'b0}}, w_lt};
                    c_OP_MIN: w_res = w_lt ? w_a : w_b;
                    c_OP_MAX: w_res = w_lt ? w_b : w_a;
                    default:  w_res = w_sum;
                endcase
            end

            assign w_laneRes[i*EW +: EW] = w_res;
            assign w_laneZero[i]         = (w_res == '0);
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Pipeline control and stage registers
    //--------------------------------------------------------------------------
    logic [STAGES:1]   r_valid;
    logic [STAGES:1]   w_load;
    logic [STAGES:1]   w_inValid;
    logic              w_accept;

    logic [c_VW-1:0]   r_data   [1:STAGES];
    logic [LANES-1:0]  r_zmask  [1:STAGES];
    logic [TAGW-1:0]   r_tag    [1:STAGES];
    logic              r_wen    [1:STAGES];

    logic [c_VW-1:0]   w_inData  [1:STAGES];
    logic [LANES-1:0]  w_inZmask [1:STAGES];
    logic [TAGW-1:0]   w_inTag   [1:STAGES];
    logic              w_inWen   [1:STAGES];

    assign w_accept = in_valid & w_load[1];
    assign in_ready = w_load[1];

    generate
        for (genvar k = 1; k <= STAGES; k++) begin : g_stage
            // A stage can load unless it and every stage after it are full
            // while the output is stalled; this collapses bubbles.
            assign w_load[k] = out_ready | ~(&r_valid[STAGES:k]);

            if (k == 1) begin : g_head
                assign w_inValid[k] = w_accept;
                assign w_inData[k]  = w_laneRes;
                assign w_inZmask[k] = w_laneZero;
                assign w_inTag[k]   = tag_in;
                assign w_inWen[k]   = wen_in;
            end else begin : g_body
                assign w_inValid[k] = r_valid[k-1];
                assign w_inData[k]  = r_data[k-1];
                assign w_inZmask[k] = r_zmask[k-1];
                assign w_inTag[k]   = r_tag[k-1];
                assign w_inWen[k]   = r_wen[k-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                r_data[k]  <= '0;
                r_zmask[k] <= '0;
                r_tag[k]   <= '0;
                r_wen[k]   <= 1'b0;
            end
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_load[k]) begin
                    r_valid[k] <= w_inValid[k];
                end
                // Payload only moves with a real op so stalled outputs stay put.
                if (w_load[k] && w_inValid[k]) begin
                    r_data[k]  <= w_inData[k];
                    r_zmask[k] <= w_inZmask[k];
                    r_tag[k]   <= w_inTag[k];
                    r_wen[k]   <= w_inWen[k];
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES];
    assign result    = r_data[STAGES];
    assign zmask     = r_zmask[STAGES];
    assign tag_out   = r_tag[STAGES];
    assign wen_out   = r_wen[STAGES] & r_valid[STAGES];

endmodule

`default_nettype wire
